// File: rtl/instr_encoder_if.sv
// Bus bundle between a beat source and the instruction encoder.
// The master side supplies session control and instruction fields; the slave
// side (the encoder) returns the handshake, the memory write port and status.
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    // Session control and field beats
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [2:0]            fmt;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [31:0]           imm;

    // Instruction-memory write port
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    // Status
    logic                  busy;
    logic                  done;
    logic                  full;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  err_illegal;
    logic                  err_misalign;

    modport master (
        output start, in_valid, in_last, fmt, opcode, rd, rs1, rs2,
               funct3, funct7, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, full,
               word_count, err_illegal, err_misalign
    );

    modport slave (
        input  start, in_valid, in_last, fmt, opcode, rd, rs1, rs2,
               funct3, funct7, imm,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, full,
               word_count, err_illegal, err_misalign
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts per-field beats describing RV32 instructions,
// packs each legal beat into its 32-bit encoding and writes it to consecutive
// words of an instruction memory. A session runs IDLE -> LOAD -> FLUSH -> DONE.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    instr_encoder_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4,
        FMT_R = 3'd5
    } fmt_e;

    state_e                state;
    state_e                state_next;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  full;
    logic                  err_illegal;
    logic                  err_misalign;

    logic                  accept;
    logic                  legal;
    logic                  branch_like;
    logic                  fills_last;
    logic [31:0]           encoded;
    logic [31:0]           imm;

    assign imm         = bus.imm;
    assign accept      = (state == LOAD) && bus.in_valid;
    assign legal       = (bus.fmt <= 3'd5);
    assign branch_like = (bus.fmt == FMT_B) || (bus.fmt == FMT_J);
    // The beat that lands in the final word ends the session on its own.
    assign fills_last  = accept && legal && (word_count == LAST_SLOT);

    // Pack the incoming fields according to the instruction format.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        encoded = '0;
        case (fmt_e'(bus.fmt))
            FMT_R: encoded = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_I: encoded = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_S: encoded = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
            FMT_B: encoded = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                              imm[4:1], imm[11], bus.opcode};
            FMT_U: encoded = {imm[31:12], bus.rd, bus.opcode};
            FMT_J: encoded = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
            default: encoded = '0;
        endcase
    end

    // State register; reset returns to IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the session sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.start) state_next = LOAD;
            LOAD:  if (accept && (bus.in_last || fills_last)) state_next = FLUSH;
            FLUSH: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write port, word counter and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every output register is reset so rst drives all outputs to 0 immediately.
        if (rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            word_count   <= '0;
            full         <= 1'b0;
            err_illegal  <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            // The write strobe lives for exactly one cycle after an accepted legal beat.
            mem_we <= 1'b0;

            if ((state == IDLE) && bus.start) begin
                word_count   <= '0;
                full         <= 1'b0;
                err_illegal  <= 1'b0;
                err_misalign <= 1'b0;
            end

            if (accept) begin
                if (legal) begin
                    mem_we     <= 1'b1;
                    mem_addr   <= word_count[ADDR_WIDTH-1:0];
                    mem_wdata  <= encoded;
                    word_count <= word_count + 1'b1;
                    if (fills_last) begin
                        full <= 1'b1;
                    end
                    // Odd branch/jump offsets are written with bit 0 dropped, but flagged.
                    if (branch_like && imm[0]) begin
                        err_misalign <= 1'b1;
                    end
                end else begin
                    err_illegal <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready     = (state == LOAD);
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.word_count   = word_count;
    assign bus.full         = full;
    assign bus.err_illegal  = err_illegal;
    assign bus.err_misalign = err_misalign;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a table of known encodings, hand-written
// corner sequences (full memory, illegal/misaligned beats, async reset) and
// randomized sessions checked against an arithmetic reference model.
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t       b;
        logic        first;
        logic [31:0] exp_data;
        int          exp_addr;
    } vec_t;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    // Reference-model session state (default instance, 256 words)
    int m_count;
    bit m_ill;
    bit m_mis;
    bit m_full;

    instr_encoder_if #(.ADDR_WIDTH(8)) bus8 ();
    instr_encoder_if #(.ADDR_WIDTH(2)) bus2 ();

    instr_encoder #(.ADDR_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    instr_encoder #(.ADDR_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Encoding computed from field positions with shifts and masks.
    function automatic logic [31:0] ref_encode(input beat_t b);
        logic [31:0] op = 32'(b.opcode);
        logic [31:0] rd = 32'(b.rd) << 7;
        logic [31:0] f3 = 32'(b.funct3) << 12;
        logic [31:0] r1 = 32'(b.rs1) << 15;
        logic [31:0] r2 = 32'(b.rs2) << 20;
        logic [31:0] im = b.imm;
        case (b.fmt)
            3'd5: return op | rd | f3 | r1 | r2 | (32'(b.funct7) << 25);
            3'd0: return op | rd | f3 | r1 | ((im & 32'hFFF) << 20);
            3'd1: return op | ((im & 32'h1F) << 7) | f3 | r1 | r2 | (((im >> 5) & 32'h7F) << 25);
            3'd2: return op | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8) | f3 | r1 | r2
                         | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
            3'd3: return op | rd | (im & 32'hFFFFF000);
            3'd4: return op | rd | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
                         | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
            default: return 32'h0;
        endcase
    endfunction

    function automatic beat_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm, input logic last);
        beat_t b;
        b.fmt = f; b.opcode = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
        b.funct3 = f3; b.funct7 = f7; b.imm = imm; b.last = last;
        return b;
    endfunction

    function automatic beat_t rand_beat(input logic last);
        beat_t b;
        b.fmt    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        b.opcode = 7'($urandom);
        b.rd     = 5'($urandom);
        b.rs1    = 5'($urandom);
        b.rs2    = 5'($urandom);
        b.funct3 = 3'($urandom);
        b.funct7 = 7'($urandom);
        b.imm    = $urandom;
        b.last   = last;
        return b;
    endfunction

    task automatic drive8(input beat_t b);
        bus8.fmt = b.fmt; bus8.opcode = b.opcode; bus8.rd = b.rd; bus8.rs1 = b.rs1;
        bus8.rs2 = b.rs2; bus8.funct3 = b.funct3; bus8.funct7 = b.funct7;
        bus8.imm = b.imm; bus8.in_last = b.last;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"},       bus8.mem_we, 0);
        check({tag, "_mem_addr"},     bus8.mem_addr, 0);
        check({tag, "_mem_wdata"},    bus8.mem_wdata, 0);
        check({tag, "_busy"},         bus8.busy, 0);
        check({tag, "_done"},         bus8.done, 0);
        check({tag, "_full"},         bus8.full, 0);
        check({tag, "_word_count"},   bus8.word_count, 0);
        check({tag, "_err_illegal"},  bus8.err_illegal, 0);
        check({tag, "_err_misalign"}, bus8.err_misalign, 0);
        check({tag, "_in_ready"},     bus8.in_ready, 0);
    endtask

    task automatic start_session();
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        m_count = 0; m_ill = 0; m_mis = 0; m_full = 0;
        check("start_busy",        bus8.busy, 1);
        check("start_in_ready",    bus8.in_ready, 1);
        check("start_word_count",  bus8.word_count, 0);
        check("start_err_illegal", bus8.err_illegal, 0);
        check("start_err_misalign", bus8.err_misalign, 0);
    endtask

    // One LOAD cycle with no beat offered; a stray start must be ignored.
    task automatic idle_cycle();
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.start = 1'($urandom_range(0, 1));
        drive8(rand_beat(1'($urandom)));
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        check("gap_mem_we",     bus8.mem_we, 0);
        check("gap_word_count", bus8.word_count, 32'(m_count));
        check("gap_in_ready",   bus8.in_ready, 1);
    endtask

    task automatic send_beat(input beat_t b, output logic [31:0] got_data, output int got_addr);
        int n = 0;
        @(negedge clk);
        drive8(b);
        bus8.in_valid = 1'b1;
        while (!bus8.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus8.in_ready) begin
            check("beat_wait_in_ready", bus8.in_ready, 1);
            bus8.in_valid = 1'b0;
            got_data = '0;
            got_addr = -1;
            return;
        end
        @(posedge clk);
        #1;
        got_data = bus8.mem_wdata;
        got_addr = int'(bus8.mem_addr);
        if (b.fmt <= 3'd5) begin
            check("beat_mem_we",    bus8.mem_we, 1);
            check("beat_mem_addr",  bus8.mem_addr, 64'(m_count));
            check("beat_mem_wdata", bus8.mem_wdata, ref_encode(b));
            m_count++;
            if ((b.fmt == 3'd2 || b.fmt == 3'd4) && b.imm[0]) m_mis = 1;
        end else begin
            check("illegal_mem_we", bus8.mem_we, 0);
            m_ill = 1;
        end
        check("beat_word_count",   bus8.word_count, 64'(m_count));
        check("beat_err_illegal",  bus8.err_illegal, m_ill);
        check("beat_err_misalign", bus8.err_misalign, m_mis);
        check("beat_in_ready",     bus8.in_ready, !b.last);
    endtask

    // After the last beat: FLUSH -> DONE (done pulse) -> IDLE with held status.
    task automatic finish_session();
        @(negedge clk);
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("done_pulse",     bus8.done, 1);
        check("done_mem_we",    bus8.mem_we, 0);
        @(posedge clk);
        #1;
        check("idle_done",         bus8.done, 0);
        check("idle_busy",         bus8.busy, 0);
        check("idle_word_count",   bus8.word_count, 64'(m_count));
        check("idle_err_illegal",  bus8.err_illegal, m_ill);
        check("idle_err_misalign", bus8.err_misalign, m_mis);
        check("idle_full",         bus8.full, m_full);
    endtask

    vec_t vecs[6];

    initial begin
        logic [31:0] d;
        int          a;
        beat_t       b;

        vectors = 0;
        miscompares = 0;
        m_count = 0; m_ill = 0; m_mis = 0; m_full = 0;

        vecs[0] = '{b: mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0),
                    first: 1'b1, exp_data: 32'h00500093, exp_addr: 0};
        vecs[1] = '{b: mk(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1),
                    first: 1'b0, exp_data: 32'h002081B3, exp_addr: 1};
        vecs[2] = '{b: mk(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0),
                    first: 1'b1, exp_data: 32'h0020A423, exp_addr: 0};
        vecs[3] = '{b: mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0),
                    first: 1'b0, exp_data: 32'hFE000EE3, exp_addr: 1};
        vecs[4] = '{b: mk(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0),
                    first: 1'b0, exp_data: 32'h008000EF, exp_addr: 2};
        vecs[5] = '{b: mk(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1),
                    first: 1'b0, exp_data: 32'h123452B7, exp_addr: 3};

        rst = 1'b1;
        bus8.start = 1'b0; bus8.in_valid = 1'b0; drive8(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        bus2.fmt = 3'd0; bus2.opcode = 7'h13; bus2.rd = 5'd0; bus2.rs1 = 5'd2;
        bus2.rs2 = 5'd0; bus2.funct3 = 3'd0; bus2.funct7 = 7'd0; bus2.imm = 32'd7;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Known encodings from the table, two sessions
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].first) start_session();
            send_beat(vecs[i].b, d, a);
            check("table_wdata", d, vecs[i].exp_data);
            check("table_addr",  64'(a), 64'(vecs[i].exp_addr));
            if (vecs[i].b.last) finish_session();
        end
        check("table_final_count", bus8.word_count, 4);

        // Randomized sessions against the reference model
        for (int s = 0; s < 25; s++) begin
            int nbeats = $urandom_range(1, 12);
            start_session();
            for (int j = 0; j < nbeats; j++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                b = rand_beat(j == nbeats - 1);
                send_beat(b, d, a);
            end
            finish_session();
        end

        // Four-word memory: the fourth write fills it and ends the session
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        @(negedge clk);
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("full_mem_we",    bus2.mem_we, 1);
            check("full_mem_addr",  bus2.mem_addr, 64'(i));
            check("full_mem_wdata", bus2.mem_wdata,
                  ref_encode(mk(3'd0, 7'h13, 5'(i), 5'd2, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0)));
            check("full_flag",      bus2.full, (i == 3));
            check("full_in_ready",  bus2.in_ready, (i != 3));
            check("full_count",     bus2.word_count, 64'(i + 1));
            bus2.rd = 5'(i + 1);
        end
        @(posedge clk);
        #1;
        check("full_done",      bus2.done, 1);
        check("full_no_write",  bus2.mem_we, 0);
        @(posedge clk);
        #1;
        check("full_idle_busy", bus2.busy, 0);
        check("full_idle_rdy",  bus2.in_ready, 0);
        check("full_held",      bus2.full, 1);
        check("full_held_cnt",  bus2.word_count, 4);
        bus2.in_valid = 1'b0;

        // Illegal format, then misaligned branch, then reset mid-LOAD
        start_session();
        send_beat(mk(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0), d, a);
        check("illegal_sticky", bus8.err_illegal, 1);
        check("illegal_count",  bus8.word_count, 0);
        send_beat(mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0), d, a);
        check("misalign_wdata", d, 32'h00000163);
        check("misalign_flag",  bus8.err_misalign, 1);
        check("misalign_count", bus8.word_count, 1);
        check("misalign_we",    bus8.mem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        bus8.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_busy", bus8.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, which sets the word address width (DEPTH = 2**ADDR_WIDTH words).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load session.
- in_valid  in  1  field beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_last  in  1  final beat of the session.
- fmt  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 R; 110/111 illegal.
- opcode  in  7  opcode field.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field.
- imm  in  32  immediate, as a signed byte offset or value.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- full  out  1  all DEPTH words written.
- word_count  out  ADDR_WIDTH+1  words written this session.
- err_illegal  out  1  sticky: illegal fmt seen.
- err_misalign  out  1  sticky: B/J imm[0]=1 seen.

Function
REQ-003 SHALL implement FSM IDLE -> LOAD -> FLUSH -> DONE -> IDLE.
REQ-004 IDLE: start=1 -> LOAD; on that edge, clear word_count, full, err_illegal and err_misalign.
REQ-005 in_ready SHALL be 1 only in LOAD; start outside IDLE is ignored.
REQ-006 Accepted beat at edge N SHALL drive mem_we=1, mem_addr=word_count (pre-increment) and mem_wdata=encoding during cycle N..N+1 (latency 1); word_count increments at edge N.
REQ-007 Encoding, {msb..lsb}:
- R: {funct7,rs2,rs1,funct3,rd,opcode}
- I: {imm[11:0],rs1,funct3,rd,opcode}
- S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
- B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
- U: {imm[31:12],rd,opcode}
- J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
REQ-008 Unused imm bits SHALL be ignored; no range checking.
REQ-009 Illegal fmt SHALL produce no write, leave word_count unchanged and set err_illegal.
REQ-010 B/J with imm[0]=1 SHALL still be written, with imm[0] dropped, and SHALL set err_misalign.
REQ-011 An accepted beat with in_last=1 SHALL move LOAD -> FLUSH, including when fmt is illegal.
REQ-012 An accepted legal beat that makes word_count == DEPTH SHALL set full and move to FLUSH regardless of in_last, so in_ready drops and no overflow is possible.
REQ-013 FLUSH -> DONE unconditionally; DONE asserts done=1 for one cycle, then -> IDLE.
REQ-014 mem_we SHALL be 0 in every cycle not covered by REQ-006.
REQ-015 word_count, full and the error flags SHALL hold their values in IDLE until the next start.

Reset
REQ-016 rst=1 SHALL immediately, without waiting for clk, force state IDLE and set every output to 0, except in_ready, which is 0 because the state is IDLE.
REQ-017 rst during LOAD or FLUSH SHALL abort the session; a pending write is dropped (mem_we=0 at once).

Verification
REQ-018 start; I beat opcode=0010011, rd=1, rs1=0, funct3=0, imm=5, in_last=0 -> mem_wdata=0x00500093, mem_addr=0 one cycle after accept.
REQ-019 S opcode=0100011, funct3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423; then B opcode=1100011, funct3=0, rs1=rs2=0, imm=-4 -> 0xFE000EE3 at mem_addr=1.
REQ-020 J opcode=1101111, rd=1, imm=8 -> 0x008000EF; U opcode=0110111, rd=5, imm=0x12345000 with in_last=1 -> 0x123452B7, then FLUSH, done pulse, IDLE, word_count=4.
REQ-021 ADDR_WIDTH=2, 5 valid beats, no in_last -> 4 writes to addr 0..3, full=1, in_ready=0 after 4th accept, done pulse.
REQ-022 fmt=110 beat, then B beat with imm=3 -> no write for first, err_illegal=1, err_misalign=1, word_count=1; rst asserted mid-LOAD -> all outputs 0 asynchronously.
